// File: rtl/inst_pipe_regs_if.sv
// rtl/inst_pipe_regs_if.sv - fetch/control inputs and per-stage outputs of the instruction pipe.
interface inst_pipe_regs_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] imem_inst;
  logic [XLEN-1:0] imem_pc;
  logic            stall;
  logic            flush;

  logic [XLEN-1:0] instF, instD, instX, instM, instW;
  logic [XLEN-1:0] pcF, pcD, pcX, pcM, pcW;
  logic            validF, validD, validX, validM, validW;
  logic            stall_timeout;
  logic [31:0]     retire_cnt;
  logic [31:0]     bubble_cnt;

  modport master (
    output imem_inst, imem_pc, stall, flush,
    input  instF, instD, instX, instM, instW,
    input  pcF, pcD, pcX, pcM, pcW,
    input  validF, validD, validX, validM, validW,
    input  stall_timeout, retire_cnt, bubble_cnt
  );

  modport slave (
    input  imem_inst, imem_pc, stall, flush,
    output instF, instD, instX, instM, instW,
    output pcF, pcD, pcX, pcM, pcW,
    output validF, validD, validX, validM, validW,
    output stall_timeout, retire_cnt, bubble_cnt
  );
endinterface

// File: rtl/inst_pipe_regs.sv
// rtl/inst_pipe_regs.sv - F/D/X/M/W instruction+PC+valid registers with stall, flush and stall watchdog.
// Optional perf counters (retire_cnt, bubble_cnt) enabled by INST_PIPE_PERF_EN.
module inst_pipe_regs #(
  parameter int                  XLEN      = 32,
  parameter logic [XLEN-1:0]     NOP_INST  = 32'h0000_0013,
  parameter logic [XLEN-1:0]     RESET_PC  = 32'h0000_0000,
  parameter int unsigned         STALL_MAX = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_pipe_regs_if.slave    bus
);

  logic       stall_only;
  logic [7:0] stall_cnt;
  logic [7:0] stall_cnt_inc;

  // Flush takes priority, so a stall coinciding with a flush is ignored.
  assign stall_only    = bus.stall & ~bus.flush;
  assign stall_cnt_inc = (stall_cnt == 8'hFF) ? 8'hFF : stall_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.instF  <= NOP_INST;
      bus.instD  <= NOP_INST;
      bus.instX  <= NOP_INST;
      bus.instM  <= NOP_INST;
      bus.instW  <= NOP_INST;
      bus.pcF    <= RESET_PC;
      bus.pcD    <= RESET_PC;
      bus.pcX    <= RESET_PC;
      bus.pcM    <= RESET_PC;
      bus.pcW    <= RESET_PC;
      bus.validF <= 1'b0;
      bus.validD <= 1'b0;
      bus.validX <= 1'b0;
      bus.validM <= 1'b0;
      bus.validW <= 1'b0;
    end else begin
      // M and W always advance so the resolving branch completes.
      bus.instM  <= bus.instX;
      bus.pcM    <= bus.pcX;
      bus.validM <= bus.validX;
      bus.instW  <= bus.instM;
      bus.pcW    <= bus.pcM;
      bus.validW <= bus.validM;

      if (bus.flush) begin
        bus.instF  <= NOP_INST;
        bus.pcF    <= bus.imem_pc;
        bus.validF <= 1'b0;
        bus.instD  <= NOP_INST;
        bus.pcD    <= bus.pcF;
        bus.validD <= 1'b0;
        bus.instX  <= NOP_INST;
        bus.pcX    <= bus.pcD;
        bus.validX <= 1'b0;
      end else if (bus.stall) begin
        bus.instX  <= NOP_INST;
        bus.pcX    <= bus.pcD;
        bus.validX <= 1'b0;
      end else begin
        bus.instF  <= bus.imem_inst;
        bus.pcF    <= bus.imem_pc;
        bus.validF <= 1'b1;
        bus.instD  <= bus.instF;
        bus.pcD    <= bus.pcF;
        bus.validD <= bus.validF;
        bus.instX  <= bus.instD;
        bus.pcX    <= bus.pcD;
        bus.validX <= bus.validD;
      end
    end
  end

  // Timeout is raised on the edge that completes the STALL_MAX-th consecutive stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt         <= 8'd0;
      bus.stall_timeout <= 1'b0;
    end else if (stall_only) begin
      stall_cnt <= stall_cnt_inc;
      if (32'(stall_cnt_inc) >= STALL_MAX) begin
        bus.stall_timeout <= 1'b1;
      end
    end else begin
      stall_cnt <= 8'd0;
    end
  end

`ifdef INST_PIPE_PERF_EN
  logic [31:0] retire_q;
  logic [31:0] bubble_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_q <= 32'd0;
      bubble_q <= 32'd0;
    end else begin
      if (bus.validW) begin
        retire_q <= retire_q + 32'd1;
      end
      if (bus.stall || bus.flush) begin
        bubble_q <= bubble_q + 32'd1;
      end
    end
  end

  assign bus.retire_cnt = retire_q;
  assign bus.bubble_cnt = bubble_q;
`else
  assign bus.retire_cnt = 32'd0;
  assign bus.bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_inst_pipe_regs.sv
// tb/tb_inst_pipe_regs.sv - directed table-driven bench for inst_pipe_regs.
module tb_inst_pipe_regs;

  localparam logic [31:0] N  = 32'h0000_0013;
  localparam logic [31:0] A  = 32'h00A0_0093;
  localparam logic [31:0] B1 = 32'h0010_0113;
  localparam logic [31:0] C  = 32'h0020_0193;
  localparam logic [31:0] BR = 32'h0020_8463;
  localparam logic [31:0] E  = 32'h0030_0213;
  localparam logic [31:0] F6 = 32'h0040_0293;
  localparam logic [31:0] G  = 32'h0050_0313;
  localparam logic [31:0] H  = 32'h0060_0393;
  localparam logic [31:0] I  = 32'h0070_0413;
  localparam logic [31:0] J  = 32'h0080_0493;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  inst_pipe_regs_if #(.XLEN(32)) bus ();

  inst_pipe_regs #(
    .XLEN(32), .NOP_INST(32'h0000_0013), .RESET_PC(32'h0000_0000), .STALL_MAX(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] inst, pc;
    logic        st, fl;
    logic [31:0] ef, ed, ex, em, ew;
    logic [31:0] epcf, epcx, epcw;
    logic        evx, evw;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic st, input logic fl);
    bus.imem_inst = inst;
    bus.imem_pc   = pc;
    bus.stall     = st;
    bus.flush     = fl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(N, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, " instF"}, bus.instF, N);
    chk({tag, " instD"}, bus.instD, N);
    chk({tag, " instX"}, bus.instX, N);
    chk({tag, " instM"}, bus.instM, N);
    chk({tag, " instW"}, bus.instW, N);
    chk({tag, " pcs"}, bus.pcF | bus.pcD | bus.pcX | bus.pcM | bus.pcW, 32'h0);
    chk({tag, " valids"}, {27'd0, bus.validF, bus.validD, bus.validX, bus.validM, bus.validW}, 32'h0);
    chk({tag, " timeout"}, {31'd0, bus.stall_timeout}, 32'h0);
    chk({tag, " retire_cnt"}, bus.retire_cnt, 32'h0);
    chk({tag, " bubble_cnt"}, bus.bubble_cnt, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{A,  32'h100, 0, 0, A,  N,  N,  N,  N,  32'h100, 32'h000, 32'h000, 0, 0};
    vecs[1]  = '{B1, 32'h104, 0, 0, B1, A,  N,  N,  N,  32'h104, 32'h000, 32'h000, 0, 0};
    vecs[2]  = '{C,  32'h108, 0, 0, C,  B1, A,  N,  N,  32'h108, 32'h100, 32'h000, 1, 0};
    vecs[3]  = '{BR, 32'h10C, 0, 0, BR, C,  B1, A,  N,  32'h10C, 32'h104, 32'h000, 1, 0};
    vecs[4]  = '{E,  32'h110, 0, 0, E,  BR, C,  B1, A,  32'h110, 32'h108, 32'h100, 1, 1};
    vecs[5]  = '{F6, 32'h114, 1, 0, E,  BR, N,  C,  B1, 32'h110, 32'h10C, 32'h104, 0, 1};
    vecs[6]  = '{F6, 32'h114, 0, 0, F6, E,  BR, N,  C,  32'h114, 32'h10C, 32'h108, 1, 1};
    vecs[7]  = '{G,  32'h118, 0, 1, N,  N,  N,  BR, N,  32'h118, 32'h110, 32'h10C, 0, 0};
    vecs[8]  = '{H,  32'h200, 0, 0, H,  N,  N,  N,  BR, 32'h200, 32'h114, 32'h10C, 0, 1};
    vecs[9]  = '{I,  32'h204, 1, 1, N,  N,  N,  N,  N,  32'h204, 32'h118, 32'h110, 0, 0};
    vecs[10] = '{J,  32'h208, 0, 0, J,  N,  N,  N,  N,  32'h208, 32'h200, 32'h114, 0, 0};

    do_reset();
    chk_all_reset("reset");

    for (int k = 0; k < 11; k++) begin
      drive(vecs[k].inst, vecs[k].pc, vecs[k].st, vecs[k].fl);
      tick();
      chk($sformatf("v%0d instF", k), bus.instF, vecs[k].ef);
      chk($sformatf("v%0d instD", k), bus.instD, vecs[k].ed);
      chk($sformatf("v%0d instX", k), bus.instX, vecs[k].ex);
      chk($sformatf("v%0d instM", k), bus.instM, vecs[k].em);
      chk($sformatf("v%0d instW", k), bus.instW, vecs[k].ew);
      chk($sformatf("v%0d pcF", k), bus.pcF, vecs[k].epcf);
      chk($sformatf("v%0d pcX", k), bus.pcX, vecs[k].epcx);
      chk($sformatf("v%0d pcW", k), bus.pcW, vecs[k].epcw);
      chk($sformatf("v%0d validX", k), {31'd0, bus.validX}, {31'd0, vecs[k].evx});
      chk($sformatf("v%0d validW", k), {31'd0, bus.validW}, {31'd0, vecs[k].evw});
      chk($sformatf("v%0d timeout", k), {31'd0, bus.stall_timeout}, 32'h0);
    end
    chk("flush validF/D", {30'd0, bus.validF, bus.validD}, 32'h2);

    // Watchdog: 15 stalls keep the flag low, the 16th raises it, it is sticky.
    drive(32'hDEAD_BEEF, 32'h300, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) tick();
    chk("wd 15 stalls", {31'd0, bus.stall_timeout}, 32'h0);
    chk("wd F held", bus.instF, J);
    chk("wd X bubble", {bus.instX[30:0], bus.validX}, {N[30:0], 1'b0});
    tick();
    chk("wd 16th stall", {31'd0, bus.stall_timeout}, 32'h1);
    drive(K_INST(0), 32'h300, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    chk("wd sticky", {31'd0, bus.stall_timeout}, 32'h1);

    // Stall+flush clears the watchdog count; a clean cycle clears it too.
    do_reset();
    chk("wd cleared by reset", {31'd0, bus.stall_timeout}, 32'h0);
    drive(A, 32'h400, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) tick();
    drive(A, 32'h500, 1'b1, 1'b1);
    tick();
    chk("sf pcF", bus.pcF, 32'h500);
    chk("sf validF", {31'd0, bus.validF}, 32'h0);
    drive(A, 32'h500, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) tick();
    chk("wd after flush", {31'd0, bus.stall_timeout}, 32'h0);
    drive(A, 32'h500, 1'b0, 1'b0);
    tick();
    drive(A, 32'h500, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) tick();
    chk("wd after clean", {31'd0, bus.stall_timeout}, 32'h0);

    // Reset mid-stream dominates stall and flush.
    drive(B1, 32'h600, 1'b1, 1'b1);
    rst_n = 1'b0;
    tick();
    chk_all_reset("midreset");
    rst_n = 1'b1;

    // Clean stream: retire count lags capture by the 5-stage depth.
    for (int k = 0; k < 15; k++) begin
      drive(K_INST(k), 32'h700 + 32'(4 * k), 1'b0, 1'b0);
      tick();
    end
    chk("stream instW", bus.instW, K_INST(10));
    chk("stream pcW", bus.pcW, 32'h728);
`ifdef INST_PIPE_PERF_EN
    chk("perf retire 10", bus.retire_cnt, 32'd10);
    chk("perf bubble 0", bus.bubble_cnt, 32'd0);
`else
    chk("perf retire off", bus.retire_cnt, 32'd0);
    chk("perf bubble off", bus.bubble_cnt, 32'd0);
`endif
    drive(A, 32'h800, 1'b1, 1'b0);
    tick();
`ifdef INST_PIPE_PERF_EN
    chk("perf retire 11", bus.retire_cnt, 32'd11);
    chk("perf bubble 1", bus.bubble_cnt, 32'd1);
`else
    chk("perf retire off2", bus.retire_cnt, 32'd0);
    chk("perf bubble off2", bus.bubble_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [31:0] K_INST(input int k);
    return 32'h0000_0093 | (32'(k + 1) << 20);
  endfunction

endmodule
